// File: rtl/axi_time_sched_if.sv
// Bus bundle for axi_time_sched: trigger queues, capture channels and time base.
// trig_valid/trig_ready: a push completes on a rising edge where both are high; valid may drop freely.
interface axi_time_sched_if #(
  parameter int COUNT_WIDTH = 64,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 4
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                          time_enable;
  logic [COUNT_WIDTH-1:0]        time_counter;
  logic [NUM_CH-1:0]             trig_valid;
  logic [NUM_CH*COUNT_WIDTH-1:0] trig_data;
  logic [NUM_CH-1:0]             trig_ready;
  logic [NUM_CH-1:0]             trig_flush;
  logic [NUM_CH-1:0]             trig_pulse;
  logic [NUM_CH-1:0]             trig_underrun;
  logic [NUM_CH-1:0]             underrun_clr;
  logic [NUM_CH*LW-1:0]          trig_level;
  logic [NUM_CH-1:0]             capture_in;
  logic [NUM_CH*COUNT_WIDTH-1:0] capture_data;
  logic [NUM_CH-1:0]             capture_valid;
  logic [NUM_CH-1:0]             capture_ack;
  logic [NUM_CH-1:0]             capture_overflow;

  modport master (
    output time_enable, time_counter, trig_valid, trig_data, trig_flush,
           underrun_clr, capture_in, capture_ack,
    input  trig_ready, trig_pulse, trig_underrun, trig_level,
           capture_data, capture_valid, capture_overflow
  );

  modport slave (
    input  time_enable, time_counter, trig_valid, trig_data, trig_flush,
           underrun_clr, capture_in, capture_ack,
    output trig_ready, trig_pulse, trig_underrun, trig_level,
           capture_data, capture_valid, capture_overflow
  );
endinterface

// File: rtl/axi_time_sched.sv
// Multi-channel timestamp scheduler: per-channel trigger queues fired against
// a shared free-running time counter, plus per-channel event capture.
module axi_time_sched #(
  parameter int COUNT_WIDTH = 64,
  parameter int NUM_CH      = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  axi_time_sched_if.slave  bus
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [COUNT_WIDTH-1:0] mem       [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr    [NUM_CH];
  logic [PW-1:0]          rd_ptr    [NUM_CH];
  logic [LW-1:0]          level     [NUM_CH];
  logic [COUNT_WIDTH-1:0] cap_data  [NUM_CH];
  logic [COUNT_WIDTH-1:0] diff      [NUM_CH];

  logic [NUM_CH-1:0] pulse_q, underrun_q, cap_valid_q, cap_ovf_q;
  logic [NUM_CH-1:0] empty, full, on_time, late, push, pop, cap_take;
  logic [NUM_CH*LW-1:0]          level_flat;
  logic [NUM_CH*COUNT_WIDTH-1:0] cap_flat;

  // Modular difference: MSB set means the head is still in the future,
  // which makes counter wrap-around transparent.
  always_comb begin
    diff       = '{default: '0};
    empty      = '0;
    full       = '0;
    on_time    = '0;
    late       = '0;
    push       = '0;
    pop        = '0;
    cap_take   = '0;
    level_flat = '0;
    cap_flat   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      diff[i]     = bus.time_counter - mem[i][rd_ptr[i]];
      empty[i]    = (level[i] == '0);
      full[i]     = (level[i] == LW'(FIFO_DEPTH));
      on_time[i]  = bus.time_enable && !empty[i] && (diff[i] == '0);
      late[i]     = bus.time_enable && !empty[i] && (diff[i] != '0) &&
                    !diff[i][COUNT_WIDTH-1];
      push[i]     = bus.trig_valid[i] && !full[i] && !bus.trig_flush[i];
      pop[i]      = (on_time[i] || late[i]) && !bus.trig_flush[i];
      cap_take[i] = bus.capture_in[i] && (!cap_valid_q[i] || bus.capture_ack[i]);
      level_flat[i*LW +: LW]               = level[i];
      cap_flat[i*COUNT_WIDTH +: COUNT_WIDTH] = cap_data[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        for (int j = 0; j < FIFO_DEPTH; j++) mem[i][j] <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        level[i]    <= '0;
        cap_data[i] <= '0;
      end
      pulse_q     <= '0;
      underrun_q  <= '0;
      cap_valid_q <= '0;
      cap_ovf_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= bus.trig_data[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
        // Flush wins over any push or pop in the same cycle.
        if (bus.trig_flush[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          level[i]  <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
          if (push[i] && !pop[i])      level[i] <= level[i] + LW'(1);
          else if (pop[i] && !push[i]) level[i] <= level[i] - LW'(1);
        end

        pulse_q[i] <= on_time[i] && !bus.trig_flush[i];

        if (late[i] && !bus.trig_flush[i]) underrun_q[i] <= 1'b1;
        else if (bus.underrun_clr[i])      underrun_q[i] <= 1'b0;

        if (cap_take[i]) begin
          cap_data[i]    <= bus.time_counter;
          cap_valid_q[i] <= 1'b1;
        end else if (bus.capture_ack[i]) begin
          cap_valid_q[i] <= 1'b0;
        end
        if (bus.capture_in[i] && cap_valid_q[i] && !bus.capture_ack[i]) begin
          cap_ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.trig_ready       = ~full;
  assign bus.trig_pulse       = pulse_q;
  assign bus.trig_underrun    = underrun_q;
  assign bus.trig_level       = level_flat;
  assign bus.capture_data     = cap_flat;
  assign bus.capture_valid    = cap_valid_q;
  assign bus.capture_overflow = cap_ovf_q;
endmodule

// File: tb/tb_axi_time_sched.sv
// Directed bench for axi_time_sched: a 64-bit 4-channel instance plus an
// 8-bit single-channel instance for counter wrap-around.
module tb_axi_time_sched;
  localparam int CW    = 64;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_time_sched_if #(.COUNT_WIDTH(CW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) sif ();
  axi_time_sched_if #(.COUNT_WIDTH(8),  .NUM_CH(1),   .FIFO_DEPTH(DEPTH)) wif ();

  axi_time_sched #(.COUNT_WIDTH(CW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .bus(sif.slave)
  );
  axi_time_sched #(.COUNT_WIDTH(8), .NUM_CH(1), .FIFO_DEPTH(DEPTH)) dut_w8 (
    .clk(clk), .reset(rst), .bus(wif.slave)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] cnt;
  logic [7:0]    wcnt;
  logic [CW-1:0] exp_v;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ts(input int ch, input logic [CW-1:0] ts);
    sif.trig_valid[ch] = 1'b1;
    sif.trig_data[ch*CW +: CW] = ts;
    tick();
    sif.trig_valid[ch] = 1'b0;
  endtask

  function automatic logic [LW-1:0] lvl(input int ch);
    return sif.trig_level[ch*LW +: LW];
  endfunction

  function automatic logic [CW-1:0] cap(input int ch);
    return sif.capture_data[ch*CW +: CW];
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},    CW'(sif.trig_level),       '0);
    check({tag, "_ready"},    CW'(sif.trig_ready),       CW'(4'hF));
    check({tag, "_pulse"},    CW'(sif.trig_pulse),       '0);
    check({tag, "_underrun"}, CW'(sif.trig_underrun),    '0);
    check({tag, "_cvalid"},   CW'(sif.capture_valid),    '0);
    check({tag, "_covf"},     CW'(sif.capture_overflow), '0);
    check({tag, "_cdata0"},   CW'(sif.capture_data == '0), 1);
    check({tag, "_w8_level"}, CW'(wif.trig_level),       '0);
  endtask

  initial begin
    rst = 1'b1;
    sif.time_enable = 1'b1; sif.time_counter = '0;
    sif.trig_valid = '0; sif.trig_data = '0; sif.trig_flush = '0;
    sif.underrun_clr = '0; sif.capture_in = '0; sif.capture_ack = '0;
    wif.time_enable = 1'b1; wif.time_counter = '0;
    wif.trig_valid = '0; wif.trig_data = '0; wif.trig_flush = '0;
    wif.underrun_clr = '0; wif.capture_in = '0; wif.capture_ack = '0;

    repeat (2) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Fire on time: ts=100 pushed at 90, pulse in the cycle counter==101.
    cnt = 90; sif.time_counter = cnt;
    push_ts(0, 100);
    check("fire_level_after_push", CW'(lvl(0)), 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      cnt = cnt + 1; sif.time_counter = cnt;
      check("fire_pulse", CW'(sif.trig_pulse[0]), CW'(cnt == 101));
      check("fire_level", CW'(lvl(0)), (cnt >= 101) ? 0 : 1);
    end
    check("fire_no_underrun", CW'(sif.trig_underrun[0]), 0);

    // Fill ch1, refuse fifth push, then late drain after a counter jump.
    cnt = 150; sif.time_counter = cnt;
    for (int k = 0; k < 4; k++) push_ts(1, CW'(200 + k));
    check("fill_ready", CW'(sif.trig_ready[1]), 0);
    check("fill_level", CW'(lvl(1)), 4);
    push_ts(1, 204);
    check("fill_refused_level", CW'(lvl(1)), 4);
    cnt = 210; sif.time_counter = cnt;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("drain_level", CW'(lvl(1)), CW'(4 - k));
      check("drain_no_pulse", CW'(sif.trig_pulse[1]), 0);
      check("drain_underrun", CW'(sif.trig_underrun[1]), 1);
    end
    tick();
    check("drain_204_not_stored", CW'(lvl(1)), 0);
    sif.underrun_clr[1] = 1'b1;
    tick();
    sif.underrun_clr[1] = 1'b0;
    check("underrun_clr", CW'(sif.trig_underrun[1]), 0);
    check("underrun_ch0_untouched", CW'(sif.trig_underrun[0]), 0);

    // Consecutive timestamps give consecutive pulses.
    cnt = 690; sif.time_counter = cnt;
    push_ts(1, 700);
    push_ts(1, 701);
    for (int k = 0; k < 14; k++) begin
      tick();
      cnt = cnt + 1; sif.time_counter = cnt;
      check("b2b_pulse", CW'(sif.trig_pulse[1]), CW'(cnt == 701 || cnt == 702));
    end
    check("b2b_no_underrun", CW'(sif.trig_underrun[1]), 0);

    // Wrap-around on the 8-bit instance: ts=0x02 pushed at 0xFC.
    wcnt = 8'hFC; wif.time_counter = wcnt;
    wif.trig_valid[0] = 1'b1; wif.trig_data = 8'h02;
    tick();
    wif.trig_valid[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      wcnt = wcnt + 8'd1; wif.time_counter = wcnt;
      check("wrap_pulse", CW'(wif.trig_pulse[0]), CW'(wcnt == 8'h03));
      check("wrap_no_underrun", CW'(wif.trig_underrun[0]), 0);
    end
    check("wrap_level", CW'(wif.trig_level), 0);

    // Flush at the due time beats both the pop and a simultaneous push.
    cnt = 40; sif.time_counter = cnt;
    push_ts(2, 50);
    cnt = 50; sif.time_counter = cnt;
    sif.trig_flush[2] = 1'b1;
    sif.trig_valid[2] = 1'b1; sif.trig_data[2*CW +: CW] = 60;
    tick();
    sif.trig_flush[2] = 1'b0; sif.trig_valid[2] = 1'b0;
    check("flush_no_pulse", CW'(sif.trig_pulse[2]), 0);
    check("flush_level", CW'(lvl(2)), 0);
    cnt = 51; sif.time_counter = cnt;
    tick();
    check("flush_no_underrun", CW'(sif.trig_underrun[2]), 0);
    cnt = 60; sif.time_counter = cnt;
    tick();
    check("flush_60_not_stored", CW'(sif.trig_pulse[2]), 0);
    check("flush_level_after", CW'(lvl(2)), 0);

    // Capture handshake on ch3.
    cnt = 500; sif.time_counter = cnt;
    sif.capture_in[3] = 1'b1; tick(); sif.capture_in[3] = 1'b0;
    exp_q.push_back(500);
    exp_v = exp_q.pop_front();
    check("cap_data_first", cap(3), exp_v);
    check("cap_valid_first", CW'(sif.capture_valid[3]), 1);
    check("cap_ovf_first", CW'(sif.capture_overflow[3]), 0);
    cnt = 510; sif.time_counter = cnt;
    sif.capture_in[3] = 1'b1; tick(); sif.capture_in[3] = 1'b0;
    exp_q.push_back(500);
    exp_v = exp_q.pop_front();
    check("cap_data_kept", cap(3), exp_v);
    check("cap_ovf_set", CW'(sif.capture_overflow[3]), 1);
    check("cap_valid_kept", CW'(sif.capture_valid[3]), 1);
    cnt = 520; sif.time_counter = cnt;
    sif.capture_in[3] = 1'b1; sif.capture_ack[3] = 1'b1; tick();
    sif.capture_in[3] = 1'b0; sif.capture_ack[3] = 1'b0;
    exp_q.push_back(520);
    exp_v = exp_q.pop_front();
    check("cap_data_ack_recapture", cap(3), exp_v);
    check("cap_valid_ack_recapture", CW'(sif.capture_valid[3]), 1);
    sif.capture_ack[3] = 1'b1; tick(); sif.capture_ack[3] = 1'b0;
    check("cap_valid_ack_clear", CW'(sif.capture_valid[3]), 0);
    check("cap_ovf_sticky", CW'(sif.capture_overflow[3]), 1);
    check("cap_data_after_ack", cap(3), 520);

    // Enable gating: ts=300 held while disabled, late once re-enabled at 305.
    cnt = 290; sif.time_counter = cnt;
    push_ts(0, 300);
    sif.time_enable = 1'b0;
    for (int c = 291; c <= 304; c++) begin
      cnt = CW'(c); sif.time_counter = cnt;
      tick();
      check("gate_no_pulse", CW'(sif.trig_pulse[0]), 0);
      check("gate_level_held", CW'(lvl(0)), 1);
    end
    cnt = 305; sif.time_counter = cnt;
    sif.time_enable = 1'b1;
    tick();
    check("gate_underrun", CW'(sif.trig_underrun[0]), 1);
    check("gate_late_no_pulse", CW'(sif.trig_pulse[0]), 0);
    check("gate_late_popped", CW'(lvl(0)), 0);

    // Reset mid-operation discards queues and pending captures.
    cnt = 900; sif.time_counter = cnt;
    push_ts(1, 1000);
    push_ts(2, 1000);
    sif.capture_in[0] = 1'b1; tick(); sif.capture_in[0] = 1'b0;
    check("pre_reset_level1", CW'(lvl(1)), 1);
    check("pre_reset_cvalid0", CW'(sif.capture_valid[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_level", CW'(sif.trig_level), 0);
    check("post_reset_ready", CW'(sif.trig_ready), CW'(4'hF));

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_time_sched.md
Name: axi_time_sched

Overview:
- Multi-channel timestamp scheduler; next generation of the single RX/TX trigger/capture pair in the axi_time family.
- Sits beside axi_time_counter in the time clock domain and consumes its free-running time_counter.
- Each of NUM_CH channels holds a queue of up to FIFO_DEPTH future trigger timestamps, emits a one-cycle pulse when the counter reaches each one, and flags late entries.
- Each channel also captures the counter value on an external event, with an acknowledge handshake and overflow detection.

Parameters:
- COUNT_WIDTH, 64, width of time_counter and of every timestamp.
- NUM_CH, 4, number of independent channels (1..16).
- FIFO_DEPTH, 4, trigger queue depth per channel; power of 2, >=2.
- LW, $clog2(FIFO_DEPTH+1), derived width of each level field; not overridable.

Ports:
- clk  in  1  time clock; all logic is synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- time_enable  in  1  global enable for trigger firing and late detection.
- time_counter  in  COUNT_WIDTH  current time; normally increments by 1 per cycle, may jump on sync or overwrite.
- trig_valid  in  NUM_CH  per-channel timestamp push request.
- trig_data  in  NUM_CH*COUNT_WIDTH  push timestamps; channel i is at [i*COUNT_WIDTH +: COUNT_WIDTH].
- trig_ready  out  NUM_CH  per-channel queue not full.
- trig_flush  in  NUM_CH  per-channel queue clear.
- trig_pulse  out  NUM_CH  one-cycle fire pulse.
- trig_underrun  out  NUM_CH  sticky late flag.
- underrun_clr  in  NUM_CH  clears trig_underrun.
- trig_level  out  NUM_CH*LW  queue occupancy (0..FIFO_DEPTH).
- capture_in  in  NUM_CH  capture strobe, level-sampled each cycle.
- capture_data  out  NUM_CH*COUNT_WIDTH  captured timestamps.
- capture_valid  out  NUM_CH  capture holding valid data.
- capture_ack  in  NUM_CH  consumer acknowledge.
- capture_overflow  out  NUM_CH  sticky; capture lost.

Behaviour:

Reset:
- Asserting reset asynchronously empties all queues and clears every register.
- While in reset: trig_pulse, trig_underrun, capture_valid, capture_overflow, capture_data and trig_level are 0.
- trig_ready = ~full, so it reads all-ones from reset onward.
- Reset mid-operation discards all queued entries and any pending capture.

Push:
- A push is accepted when trig_valid[i] & trig_ready[i] at a rising edge.
- When the queue is full, trig_ready[i] is 0 and the push is refused, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle on a non-full, non-empty queue leave the level unchanged.
- A timestamp pushed into an empty queue becomes the head, and is first compared, in the cycle after the write.

Flush:
- trig_flush[i] empties queue i at the next edge.
- It overrides any push and any pop in that cycle.
- It suppresses trig_pulse for that cycle.

Compare (per channel, queue non-empty, time_enable=1):
- diff = time_counter - head, computed modulo 2^COUNT_WIDTH.
- diff == 0 (on time): pop head; trig_pulse[i]=1 in the next cycle.
- diff != 0 and diff MSB == 0 (late, up to 2^(COUNT_WIDTH-1)-1 counts): pop head; no pulse; trig_underrun[i] set.
- diff MSB == 1 (future): hold; no action.
- At most one pop per channel per cycle. Several late entries therefore drain one per cycle, each setting underrun.
- Counter wrap-around is handled implicitly by the modular difference.

time_enable=0:
- No compares, pops or pulses.
- Pushes, flushes and captures still operate.
- trig_pulse is forced 0 in the cycle after time_enable falls.

trig_pulse:
- Registered output, high for exactly one cycle per on-time entry.
- Back-to-back entries with consecutive timestamps give consecutive pulses.

trig_underrun:
- Sticky flag.
- underrun_clr[i] clears it; if a set and a clear occur in the same cycle, set wins.

Capture:
- When capture_in[i]=1 and (capture_valid[i]=0 or capture_ack[i]=1): capture_data[i] <= time_counter, and capture_valid[i]=1 from the next cycle.
- capture_ack[i] with no new capture clears capture_valid[i] at the next edge.
- capture_in[i]=1 while capture_valid[i]=1 and capture_ack[i]=0: data is kept (not overwritten) and capture_overflow[i] is set (sticky).
- capture_overflow[i] is cleared only by reset.

Channel independence:
- Channels are fully independent.
- No arbitration or shared state exists besides time_counter and time_enable.

Test Plan:
- Fire on time: NUM_CH=4; push ch0 ts=100 at counter=90, counter increments by 1 -> trig_pulse[0] high exactly in the cycle counter==101; trig_level[0] 1->0; no underrun.
- Fill and late drain: push 4 entries 200,201,202,203 on ch1 -> 5th push sees trig_ready[1]=0. Then jump counter 150->210 -> four consecutive pops, no pulses, trig_underrun[1]=1. Pulse underrun_clr[1] -> flag 0.
- Wrap-around: COUNT_WIDTH=8; push ts=0x02 at counter=0xFC -> waits, pulses in the cycle after counter==0x02, no underrun.
- Flush priority: ch2 holds ts=50; at counter=50 assert trig_flush[2] with a push of 60 -> no pulse, trig_level[2]=0, 60 not stored.
- Capture handshake: capture_in[3] at counter=500 -> capture_data[3]=500, valid=1. Capture at 510 without ack -> data stays 500, overflow=1. Ack and capture in the same cycle at counter=520 -> data=520, valid=1.
- Enable gating and reset: ts=300 queued, time_enable=0 across counter 300 -> no pulse. Re-enable at 305 -> underrun set. Assert reset mid-queue -> all levels 0, all outputs 0, trig_ready all-ones.
